mem_arbiter: RTL and testbench

Shares one single-port, variable-latency memory between the core's instruction-fetch port and its data-memory port. Generates the pipeline `stall` that the core top gates into its stage enables (`EN = ~stall`). Data accesses have priority, with a starvation bound for fetch. Sits between the core top and the unified memory model/controller.

---
 rtl/mem_arbiter_pkg.sv | 32 +++
 rtl/mem_arbiter_timer.sv | 39 +++
 rtl/mem_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_mem_arbiter.sv | 396 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg
// Shared types and defaults for the instruction/data memory arbiter.
//   arbState_t    : arbiter FSM states (IDLE, BUSY_IF, BUSY_DM)
//   grant_t       : one-cycle grant decision made in IDLE
//   DEF_*         : default STARVE_LIMIT / TIMEOUT values
//   busyStateFor  : maps a grant to the BUSY state that services it
package mem_arbiter_pkg;

  localparam int DEF_STARVE_LIMIT = 4;
  localparam int DEF_TIMEOUT      = 64;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_DM = 2'd2
  } arbState_t;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_IF   = 2'd1,
    GNT_DM   = 2'd2
  } grant_t;

  function automatic arbState_t busyStateFor(input grant_t g);
    case (g)
      GNT_IF:  return BUSY_IF;
      GNT_DM:  return BUSY_DM;
      default: return IDLE;
    endcase
  endfunction

endpackage

// File: rtl/mem_arbiter_timer.sv
// mem_arbiter_timer
// Watchdog for one memory access. Cleared when a grant is issued, counts
// every cycle the arbiter is busy, and flags expiry in the TIMEOUT-th busy
// cycle so the arbiter can abandon the access at that clock edge.
// Ports:
//   clk, rst : clock and asynchronous active-high reset
//   load     : grant issued this cycle, restart from zero
//   run      : arbiter is in a BUSY state
//   expire   : this is the TIMEOUT-th busy cycle without completion
module mem_arbiter_timer
  import mem_arbiter_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic run,
  output logic expire
);

  localparam int CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(TIMEOUT - 1);

  logic [CntW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= '0;
    end else if (run && !expire) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expire = run && (cnt == LastCnt);

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter
// Shares one single-port, variable-latency memory between the instruction
// fetch port and the data port of the core, and produces the pipeline stall.
// Data accesses win ties, but after STARVE_LIMIT consecutive data grants
// against a waiting fetch, the fetch is served next.
// Optional build macro MEM_ARBITER_TIMEOUT_EN adds a per-access watchdog
// that abandons an access after TIMEOUT busy cycles and raises bus_err.
// Ports:
//   CLK, RST                     : clock, asynchronous active-high reset
//   if_req, if_addr              : fetch request / byte address
//   if_rdata, if_valid           : fetched word (registered) / served flag
//   dm_rd, dm_wr                 : data read / write request (both -> write)
//   dm_addr, dm_wdata            : data address / write data
//   dm_rdata, dm_valid           : load data (registered) / served flag
//   stall                        : combinational pipeline freeze
//   mem_req, mem_we              : registered memory request / write enable
//   mem_addr, mem_wdata          : registered memory address / write data
//   mem_rdata, mem_ack           : memory read data / single-cycle completion
//   bus_err                      : sticky timeout flag (0 without the macro)
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int N            = 32,
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT,
  parameter int TIMEOUT      = DEF_TIMEOUT
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         if_req,
  input  logic [N-1:0] if_addr,
  output logic [N-1:0] if_rdata,
  output logic         if_valid,
  input  logic         dm_rd,
  input  logic         dm_wr,
  input  logic [N-1:0] dm_addr,
  input  logic [N-1:0] dm_wdata,
  output logic [N-1:0] dm_rdata,
  output logic         dm_valid,
  output logic         stall,
  output logic         mem_req,
  output logic         mem_we,
  output logic [N-1:0] mem_addr,
  output logic [N-1:0] mem_wdata,
  input  logic [N-1:0] mem_rdata,
  input  logic         mem_ack,
  output logic         bus_err
);

  if (STARVE_LIMIT < 1 || TIMEOUT < 1) begin : gParamCheck
    $error("mem_arbiter: STARVE_LIMIT and TIMEOUT must both be at least 1");
  end

  localparam int CntW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CntW-1:0] StarveMax = CntW'(STARVE_LIMIT);

  arbState_t       state, nextState;
  grant_t          grant;
  logic            accessEnd;
  logic            expired;
  logic            ifDone, dmDone;
  logic            dmPend, ifElig, dmElig;
  logic [CntW-1:0] starveCnt;

  // A port stays ineligible once served until the pipeline advances, so a
  // held request is never serviced twice.
  assign dmPend = dm_rd | dm_wr;
  assign ifElig = if_req & ~ifDone;
  assign dmElig = dmPend & ~dmDone;
  assign stall  = ifElig | dmElig;

  assign if_valid = ifDone;
  assign dm_valid = dmDone;

`ifdef MEM_ARBITER_TIMEOUT_EN
  logic busy;
  assign busy = (state != IDLE);

  mem_arbiter_timer #(
    .TIMEOUT(TIMEOUT)
  ) uTimer (
    .clk    (CLK),
    .rst    (RST),
    .load   (grant != GNT_NONE),
    .run    (busy),
    .expire (expired)
  );

  // A real ack in the expiry cycle still completes the access normally.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      bus_err <= 1'b0;
    end else if (busy && expired && !mem_ack) begin
      bus_err <= 1'b1;
    end
  end
`else
  assign expired = 1'b0;
  assign bus_err = 1'b0;
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    grant     = GNT_NONE;
    nextState = state;
    accessEnd = 1'b0;
    unique case (state)
      IDLE: begin
        if (ifElig && dmElig) begin
          grant = (starveCnt == StarveMax) ? GNT_IF : GNT_DM;
        end else if (dmElig) begin
          grant = GNT_DM;
        end else if (ifElig) begin
          grant = GNT_IF;
        end
        nextState = busyStateFor(grant);
      end
      BUSY_IF, BUSY_DM: begin
        if (mem_ack || expired) begin
          accessEnd = 1'b1;
          nextState = IDLE;
        end
      end
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
      ifDone    <= 1'b0;
      dmDone    <= 1'b0;
      starveCnt <= '0;
    end else begin
      // Pipeline advanced this cycle: served flags are consumed.
      if (!stall) begin
        ifDone <= 1'b0;
        dmDone <= 1'b0;
      end

      unique case (grant)
        GNT_IF: begin
          mem_req   <= 1'b1;
          mem_we    <= 1'b0;
          mem_addr  <= if_addr;
          mem_wdata <= '0;
        end
        GNT_DM: begin
          mem_req   <= 1'b1;
          mem_we    <= dm_wr;
          mem_addr  <= dm_addr;
          mem_wdata <= dm_wdata;
        end
        default: ;
      endcase

      // Only data grants that actually made a fetch wait count as starvation.
      if (grant == GNT_IF) begin
        starveCnt <= '0;
      end else if (grant == GNT_DM && ifElig && starveCnt != StarveMax) begin
        starveCnt <= starveCnt + 1'b1;
      end

      // An abandoned (timed-out) access returns zero read data.
      if (accessEnd) begin
        mem_req <= 1'b0;
        if (state == BUSY_IF) begin
          ifDone   <= 1'b1;
          if_rdata <= mem_ack ? mem_rdata : '0;
        end else begin
          dmDone <= 1'b1;
          if (!mem_we) begin
            dm_rdata <= mem_ack ? mem_rdata : '0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
`timescale 1ns/1ps
module tb_mem_arbiter;

  localparam int N = 32;

  logic         CLK = 1'b0;
  logic         RST;
  logic         if_req;
  logic [N-1:0] if_addr;
  logic [N-1:0] if_rdata;
  logic         if_valid;
  logic         dm_rd;
  logic         dm_wr;
  logic [N-1:0] dm_addr;
  logic [N-1:0] dm_wdata;
  logic [N-1:0] dm_rdata;
  logic         dm_valid;
  logic         stall;
  logic         mem_req;
  logic         mem_we;
  logic [N-1:0] mem_addr;
  logic [N-1:0] mem_wdata;
  logic [N-1:0] mem_rdata;
  logic         mem_ack;
  logic         bus_err;

  int checks = 0;
  int fails  = 0;

  // Memory model controls
  int           memWaitCycles = 0;
  int           memWaitCnt    = 0;
  bit           memNeverAck   = 1'b0;
  bit           memForceAck   = 1'b0;
  logic [N-1:0] memReadVal    = '0;

  mem_arbiter #(
    .N(N),
    .STARVE_LIMIT(4),
    .TIMEOUT(8)
  ) dut (
    .CLK(CLK), .RST(RST),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
    .dm_rd(dm_rd), .dm_wr(dm_wr), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_valid(dm_valid), .stall(stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .bus_err(bus_err)
  );

  always #5 CLK = ~CLK;

  // Memory: acks in the (memWaitCycles+1)-th cycle that mem_req is high.
  always @(negedge CLK) begin
    if (memForceAck) begin
      mem_ack   = 1'b1;
      mem_rdata = memReadVal;
    end else if (mem_req && !memNeverAck) begin
      if (memWaitCnt == memWaitCycles) begin
        mem_ack    = 1'b1;
        mem_rdata  = memReadVal;
        memWaitCnt = 0;
      end else begin
        mem_ack    = 1'b0;
        memWaitCnt = memWaitCnt + 1;
      end
    end else begin
      mem_ack    = 1'b0;
      memWaitCnt = 0;
    end
  end

  task automatic nextCycle();
    @(negedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    if_req = 1'b0; dm_rd = 1'b0; dm_wr = 1'b0;
    if_addr = '0; dm_addr = '0; dm_wdata = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    repeat (2) nextCycle();
    checks++;
    if ({mem_req, mem_we, if_valid, dm_valid, bus_err, stall} !== 6'b0) begin
      fails++;
      $display("FAIL reset_ctrl got=%b exp=000000", {mem_req, mem_we, if_valid, dm_valid, bus_err, stall});
    end
    checks++;
    if ({mem_addr, mem_wdata, if_rdata, dm_rdata} !== 128'h0) begin
      fails++;
      $display("FAIL reset_data got=%h exp=0", {mem_addr, mem_wdata, if_rdata, dm_rdata});
    end
    RST = 1'b0;
    nextCycle();
  endtask

  task automatic test_fetch_wait();
    int stallCnt = 0;
    int reqCnt = 0;
    logic [N-1:0] seenAddr = '0;
    logic seenWe = 1'b1;
    memWaitCycles = 2;
    memReadVal = 32'h00500093;
    if_addr = 32'h100;
    if_req = 1'b1;
    #1;
    for (int i = 0; i < 20; i++) begin
      if (!stall) break;
      stallCnt++;
      if (mem_req) begin
        reqCnt++;
        seenAddr = mem_addr;
        seenWe = mem_we;
      end
      nextCycle();
    end
    checks++;
    if (stallCnt != 4) begin
      fails++; $display("FAIL fetch_stall_cycles got=%0d exp=4", stallCnt);
    end
    checks++;
    if (reqCnt != 3 || seenAddr !== 32'h100 || seenWe !== 1'b0) begin
      fails++;
      $display("FAIL fetch_mem_req got cycles=%0d addr=%h we=%b exp cycles=3 addr=100 we=0", reqCnt, seenAddr, seenWe);
    end
    checks++;
    if (if_valid !== 1'b1 || if_rdata !== 32'h00500093 || dm_valid !== 1'b0) begin
      fails++;
      $display("FAIL fetch_result got valid=%b rdata=%h dmv=%b exp 1 00500093 0", if_valid, if_rdata, dm_valid);
    end
    if_req = 1'b0;
    nextCycle();
    checks++;
    if (if_valid !== 1'b0) begin
      fails++; $display("FAIL fetch_valid_clear got=%b exp=0", if_valid);
    end
  endtask

  task automatic test_dm_read();
    int stallCnt = 0;
    memWaitCycles = 1;
    memReadVal = 32'h11223344;
    dm_addr = 32'h40;
    dm_rd = 1'b1;
    #1;
    for (int i = 0; i < 20; i++) begin
      if (!stall) break;
      stallCnt++;
      nextCycle();
    end
    checks++;
    if (stallCnt != 3) begin
      fails++; $display("FAIL dmread_stall_cycles got=%0d exp=3", stallCnt);
    end
    checks++;
    if (dm_valid !== 1'b1 || dm_rdata !== 32'h11223344 || if_valid !== 1'b0) begin
      fails++;
      $display("FAIL dmread_result got valid=%b rdata=%h ifv=%b exp 1 11223344 0", dm_valid, dm_rdata, if_valid);
    end
    dm_rd = 1'b0;
    nextCycle();
  endtask

  task automatic test_concurrent();
    memWaitCycles = 0;
    memReadVal = 32'h00000013;
    if_req = 1'b1; if_addr = 32'h104;
    dm_wr = 1'b1; dm_addr = 32'h2000; dm_wdata = 32'hCAFEF00D;
    nextCycle();
    checks++;
    if ({mem_req, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, 32'h2000, 32'hCAFEF00D}) begin
      fails++;
      $display("FAIL conc_dm_first got req=%b we=%b addr=%h wdata=%h exp 1 1 00002000 cafef00d", mem_req, mem_we, mem_addr, mem_wdata);
    end
    nextCycle();
    checks++;
    if ({mem_req, dm_valid, if_valid, stall} !== 4'b0101) begin
      fails++;
      $display("FAIL conc_gap got req/dmv/ifv/stall=%b exp=0101", {mem_req, dm_valid, if_valid, stall});
    end
    nextCycle();
    checks++;
    if ({mem_req, mem_we, mem_addr} !== {1'b1, 1'b0, 32'h104}) begin
      fails++;
      $display("FAIL conc_if_second got req=%b we=%b addr=%h exp 1 0 00000104", mem_req, mem_we, mem_addr);
    end
    nextCycle();
    checks++;
    if ({if_valid, dm_valid, stall} !== 3'b110 || if_rdata !== 32'h00000013) begin
      fails++;
      $display("FAIL conc_both_valid got ifv/dmv/stall=%b rdata=%h exp 110 00000013", {if_valid, dm_valid, stall}, if_rdata);
    end
    if_req = 1'b0; dm_wr = 1'b0;
    nextCycle();
    checks++;
    if ({if_valid, dm_valid, mem_req} !== 3'b000 || dm_rdata !== 32'h11223344) begin
      fails++;
      $display("FAIL conc_after got ifv/dmv/req=%b dm_rdata=%h exp 000 11223344", {if_valid, dm_valid, mem_req}, dm_rdata);
    end
  endtask

  task automatic test_rdwr_both();
    memWaitCycles = 0;
    memReadVal = 32'hDEADBEEF;
    dm_rd = 1'b1; dm_wr = 1'b1; dm_addr = 32'h44; dm_wdata = 32'h55AA55AA;
    nextCycle();
    checks++;
    if ({mem_req, mem_we, mem_wdata} !== {1'b1, 1'b1, 32'h55AA55AA}) begin
      fails++;
      $display("FAIL rdwr_is_write got req=%b we=%b wdata=%h exp 1 1 55aa55aa", mem_req, mem_we, mem_wdata);
    end
    nextCycle();
    checks++;
    if (dm_valid !== 1'b1 || dm_rdata !== 32'h11223344) begin
      fails++;
      $display("FAIL rdwr_rdata_kept got valid=%b rdata=%h exp 1 11223344", dm_valid, dm_rdata);
    end
    dm_rd = 1'b0; dm_wr = 1'b0;
    nextCycle();
  endtask

  task automatic test_starvation();
    memWaitCycles = 0;
    memReadVal = 32'h00000013;
    // Four data grants while a fetch is eligible; fetch backs off after each.
    for (int r = 1; r <= 4; r++) begin
      if_req = 1'b1; if_addr = 32'h400;
      dm_rd = 1'b1; dm_addr = 32'h3000 + 32'(4 * r);
      nextCycle();
      checks++;
      if ({mem_req, mem_we, mem_addr} !== {1'b1, 1'b0, 32'h3000 + 32'(4 * r)}) begin
        fails++;
        $display("FAIL starve_dm_round%0d got req=%b we=%b addr=%h exp 1 0 %h", r, mem_req, mem_we, mem_addr, 32'h3000 + 32'(4 * r));
      end
      nextCycle();
      if_req = 1'b0; dm_rd = 1'b0;
      nextCycle();
    end
    // Fifth contested grant must go to fetch.
    if_req = 1'b1; if_addr = 32'h400;
    dm_rd = 1'b1; dm_addr = 32'h3014;
    nextCycle();
    checks++;
    if ({mem_req, mem_we, mem_addr} !== {1'b1, 1'b0, 32'h400}) begin
      fails++;
      $display("FAIL starve_if_fifth got req=%b we=%b addr=%h exp 1 0 00000400", mem_req, mem_we, mem_addr);
    end
    nextCycle();
    nextCycle();
    checks++;
    if ({mem_req, mem_addr} !== {1'b1, 32'h3014}) begin
      fails++;
      $display("FAIL starve_dm_after got req=%b addr=%h exp 1 00003014", mem_req, mem_addr);
    end
    nextCycle();
    checks++;
    if ({if_valid, dm_valid, stall} !== 3'b110) begin
      fails++;
      $display("FAIL starve_both_valid got ifv/dmv/stall=%b exp=110", {if_valid, dm_valid, stall});
    end
    if_req = 1'b0; dm_rd = 1'b0;
    nextCycle();
    // Counter cleared by the fetch grant: data wins the next contest.
    if_req = 1'b1; dm_rd = 1'b1; dm_addr = 32'h3018;
    nextCycle();
    checks++;
    if ({mem_req, mem_addr} !== {1'b1, 32'h3018}) begin
      fails++;
      $display("FAIL starve_cnt_cleared got req=%b addr=%h exp 1 00003018", mem_req, mem_addr);
    end
    repeat (3) nextCycle();
    if_req = 1'b0; dm_rd = 1'b0;
    nextCycle();
  endtask

  task automatic test_ack_outside_busy();
    memReadVal = 32'hFFFFFFFF;
    memForceAck = 1'b1;
    repeat (3) nextCycle();
    checks++;
    if ({mem_req, if_valid, dm_valid} !== 3'b000 || if_rdata !== 32'h13 || dm_rdata !== 32'h13) begin
      fails++;
      $display("FAIL stray_ack got req/ifv/dmv=%b if_rdata=%h dm_rdata=%h exp 000 00000013 00000013", {mem_req, if_valid, dm_valid}, if_rdata, dm_rdata);
    end
    memForceAck = 1'b0;
    nextCycle();
  endtask

  task automatic test_reset_mid_busy();
    int stallCnt = 0;
    logic [N-1:0] seenAddr = '0;
    memNeverAck = 1'b1;
    if_req = 1'b1; if_addr = 32'h500;
    nextCycle();
    checks++;
    if (mem_req !== 1'b1) begin
      fails++; $display("FAIL rstbusy_req_before got=%b exp=1", mem_req);
    end
    nextCycle();
    RST = 1'b1;
    #1;
    checks++;
    if ({mem_req, mem_we, if_valid, dm_valid, bus_err} !== 5'b0 ||
        {mem_addr, mem_wdata, if_rdata, dm_rdata} !== 128'h0) begin
      fails++;
      $display("FAIL rstbusy_outputs got ctrl=%b data=%h exp 0", {mem_req, mem_we, if_valid, dm_valid, bus_err}, {mem_addr, mem_wdata, if_rdata, dm_rdata});
    end
    if_req = 1'b0;
    nextCycle();
    RST = 1'b0;
    memNeverAck = 1'b0;
    memWaitCycles = 0;
    memReadVal = 32'h00A00113;
    nextCycle();
    if_req = 1'b1; if_addr = 32'h200;
    #1;
    for (int i = 0; i < 20; i++) begin
      if (!stall) break;
      stallCnt++;
      if (mem_req) seenAddr = mem_addr;
      nextCycle();
    end
    checks++;
    if (stallCnt != 2 || seenAddr !== 32'h200 || if_valid !== 1'b1 || if_rdata !== 32'h00A00113) begin
      fails++;
      $display("FAIL rstbusy_recover got stall=%0d addr=%h valid=%b rdata=%h exp 2 00000200 1 00a00113", stallCnt, seenAddr, if_valid, if_rdata);
    end
    if_req = 1'b0;
    nextCycle();
  endtask

  task automatic test_timeout();
`ifdef MEM_ARBITER_TIMEOUT_EN
    int reqCnt = 0;
    memNeverAck = 1'b1;
    dm_rd = 1'b1; dm_addr = 32'h60;
    #1;
    for (int i = 0; i < 40; i++) begin
      if (!stall) break;
      if (mem_req) reqCnt++;
      nextCycle();
    end
    checks++;
    if (reqCnt != 8 || stall !== 1'b0) begin
      fails++; $display("FAIL timeout_req_cycles got=%0d stall=%b exp 8 0", reqCnt, stall);
    end
    checks++;
    if ({mem_req, dm_valid, bus_err} !== 3'b011 || dm_rdata !== 32'h0) begin
      fails++;
      $display("FAIL timeout_result got req/dmv/err=%b rdata=%h exp 011 00000000", {mem_req, dm_valid, bus_err}, dm_rdata);
    end
    dm_rd = 1'b0;
    memNeverAck = 1'b0;
    repeat (3) nextCycle();
    checks++;
    if (bus_err !== 1'b1) begin
      fails++; $display("FAIL timeout_sticky got=%b exp=1", bus_err);
    end
    RST = 1'b1;
    #1;
    checks++;
    if (bus_err !== 1'b0) begin
      fails++; $display("FAIL timeout_rst_clear got=%b exp=0", bus_err);
    end
    nextCycle();
    RST = 1'b0;
    nextCycle();
`else
    checks++;
    if (bus_err !== 1'b0) begin
      fails++; $display("FAIL bus_err_tied got=%b exp=0", bus_err);
    end
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "tb_mem_arbiter watchdog");
  end

  initial begin
    test_reset();
    test_fetch_wait();
    test_dm_read();
    test_concurrent();
    test_rdwr_both();
    test_starvation();
    test_ack_outside_busy();
    test_reset_mid_busy();
    test_timeout();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
